pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 Parameter CNT_W, default 16, SHALL be the width of the taken-branch counter.
REQ-004 Ports SHALL be, clock and reset first:
  clk        in   1      rising-edge clock
  rst_n      in   1      async active-low reset
  br_en      in   1      a BNE branch is resolving this cycle
  br_res     in   1      branch-compare result, 1 = RD1 != RD2 (taken)
  br_pc      in   32     PC of the resolving branch
  imm        in   32     sign-extended branch offset
  stall      in   1      hold PC (downstream not ready)
  pc         out  32     current fetch PC
  pc_valid   out  1      pc is a valid fetch address this cycle
  flush      out  1      discard wrong-path instruction(s)
  trap       out  1      misaligned branch target detected
  taken_cnt  out  CNT_W  count of taken branches, saturating

Function
REQ-005 Target SHALL be br_pc + imm, 32-bit modulo (wrap-around, no carry out).
REQ-006 Taken SHALL be br_en & br_res, sampled only in state RUN.
REQ-007 States SHALL be BOOT, RUN, FLUSH, TRAP.
REQ-008 BOOT: pc = RESET_PC, pc_valid = 0; next state is always RUN, pc unchanged.
REQ-009 RUN, pc_valid = 1; next-edge priority: taken with target[1:0] != 0 -> TRAP, pc held; taken and aligned -> FLUSH, pc <= target; else stall = 1 -> pc held; else pc <= pc + 4.
REQ-010 Taken SHALL override stall in the same cycle.
REQ-011 FLUSH: flush = 1, pc_valid = 0, pc held at target; br_en/br_res ignored (wrong path); next state RUN regardless of stall.
REQ-012 TRAP: trap = 1, pc_valid = 0, pc frozen; the block SHALL stay in TRAP until reset.
REQ-013 flush and trap SHALL be registered (state-decoded) outputs, never combinational from inputs.
REQ-014 Branch-to-PC latency: taken at edge N -> pc = target at N+1 (pc_valid = 0), pc_valid = 1 at N+2.
REQ-015 taken_cnt SHALL increment on every aligned taken branch accepted in RUN, saturate at all-ones, never wrap.
REQ-016 A misaligned taken branch SHALL NOT increment taken_cnt.
REQ-017 pc + 4 at 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 without error.

Reset
REQ-018 On rst_n = 0, asynchronously: state = BOOT, pc = RESET_PC, pc_valid = 0, flush = 0, trap = 0, taken_cnt = 0.
REQ-019 Reset asserted mid-FLUSH or in TRAP SHALL abandon the redirect/trap immediately and restart in BOOT.
REQ-020 Release of rst_n SHALL be synchronous to clk; first active edge moves BOOT -> RUN.

Structure
REQ-021 A shared package pc_branch_pkg SHALL hold the state encoding (BOOT, RUN, FLUSH, TRAP), INSTR_BYTES = 4 and the default RESET_PC.
REQ-022 One combinational sub-module pc_target_adder SHALL compute target = br_pc + imm and misaligned = |target[1:0].
REQ-023 All state, pc and counter registers SHALL live in pc_branch_unit; no other sub-modules.

Verification
REQ-024 Reset release, no branches, stall = 0 -> pc 0x0, 0x4, 0x8, 0xC on successive cycles from RUN; pc_valid = 0 only in BOOT.
REQ-025 In RUN, br_en = 1, br_res = 1, br_pc = 0x100, imm = 0xFFFF_FFF0 -> next cycle pc = 0xF0, flush = 1, pc_valid = 0; following cycle pc = 0xF0, pc_valid = 1; taken_cnt += 1.
REQ-026 br_en = 1, br_res = 0, stall = 1 -> pc held, no flush; same with br_res = 1 -> redirect to target despite stall.
REQ-027 Taken branch br_pc = 0x200, imm = 0x6 -> trap = 1 next cycle, pc frozen at its pre-branch value, pc_valid = 0, taken_cnt unchanged; stays until rst_n = 0.
REQ-028 Force taken_cnt to all-ones (CNT_W = 4, 16 taken branches) -> value stays 4'hF on further taken branches; rst_n pulse during FLUSH -> pc = RESET_PC, flush = 0 immediately.

Source files
------------

// File: rtl/pc_branch_pkg.sv
// Shared definitions for the fetch PC / BNE branch redirect unit:
// FSM state encoding, instruction size and the default reset vector.
package pc_branch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      TRAP  = 2'd3
   } state_t;

   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_adder.sv
// Branch target computation: target = br_pc + imm (32-bit wrap-around),
// flagged as misaligned when it is not on a 4-byte instruction boundary.
module pc_target_adder (
   input  logic [31:0] br_pc,
   input  logic [31:0] imm,
   output logic [31:0] target,
   output logic        misaligned
);

   // Pure combinational add; the carry out is intentionally dropped.
   always_comb begin
      target     = br_pc + imm;
      misaligned = |target[1:0];
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC sequencer with BNE redirect, wrong-path flush, misaligned-target
// trap and a saturating count of taken branches. All outputs are registered.
module pc_branch_unit
   import pc_branch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_en,
   input  logic             br_res,
   input  logic [31:0]      br_pc,
   input  logic [31:0]      imm,
   input  logic             stall,
   output logic [31:0]      pc,
   output logic             pc_valid,
   output logic             flush,
   output logic             trap,
   output logic [CNT_W-1:0] taken_cnt
);

   state_t      state;
   logic [31:0] target;
   logic        misaligned;
   logic        taken;

   pc_target_adder u_target_adder (
      .br_pc      (br_pc),
      .imm        (imm),
      .target     (target),
      .misaligned (misaligned)
   );

   // Branch resolution request; only acted upon while in RUN.
   always_comb begin
      taken = br_en & br_res;
   end

   // Single FSM register block: state, PC, counter and state-decoded outputs
   // all update together so flush/trap/pc_valid never glitch from inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         pc_valid  <= 1'b0;
         flush     <= 1'b0;
         trap      <= 1'b0;
         taken_cnt <= '0;
      end else begin
         unique case (state)
            BOOT: begin
               state    <= RUN;
               pc_valid <= 1'b1;
               flush    <= 1'b0;
               trap     <= 1'b0;
            end
            RUN: begin
               if (taken && misaligned) begin
                  state    <= TRAP;
                  pc_valid <= 1'b0;
                  trap     <= 1'b1;
               end else if (taken) begin
                  state    <= FLUSH;
                  pc       <= target;
                  pc_valid <= 1'b0;
                  flush    <= 1'b1;
                  if (taken_cnt != {CNT_W{1'b1}}) begin
                     taken_cnt <= taken_cnt + CNT_W'(1);
                  end
               end else if (!stall) begin
                  pc <= pc + 32'(INSTR_BYTES);
               end
            end
            FLUSH: begin
               state    <= RUN;
               pc_valid <= 1'b1;
               flush    <= 1'b0;
            end
            TRAP: begin
               state    <= TRAP;
               pc_valid <= 1'b0;
               trap     <= 1'b1;
            end
            default: begin
               state    <= BOOT;
               pc       <= RESET_PC;
               pc_valid <= 1'b0;
               flush    <= 1'b0;
               trap     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit (CNT_W = 4 so saturation is reachable).
// Directed vector table, hand-written reset/saturation/wrap sequences, then
// random stimulus against a behavioural model of the fetch/branch rules.
module tb_pc_branch_unit;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             br_en;
   logic             br_res;
   logic [31:0]      br_pc;
   logic [31:0]      imm;
   logic             stall;
   logic [31:0]      pc;
   logic             pc_valid;
   logic             flush;
   logic             trap;
   logic [CNT_W-1:0] taken_cnt;

   int checks = 0;
   int errors = 0;

   // Behavioural model: phase flags rather than a state encoding
   bit          m_boot;
   bit          m_flush;
   bit          m_trap;
   logic [31:0] m_pc;
   int          m_cnt;

   typedef struct {
      bit          en;
      bit          res;
      logic [31:0] bpc;
      logic [31:0] im;
      bit          st;
      logic [31:0] e_pc;
      bit          e_valid;
      bit          e_flush;
      bit          e_trap;
      int          e_cnt;
   } vec_t;

   vec_t vecs [13];

   pc_branch_unit #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .br_en     (br_en),
      .br_res    (br_res),
      .br_pc     (br_pc),
      .imm       (imm),
      .stall     (stall),
      .pc        (pc),
      .pc_valid  (pc_valid),
      .flush     (flush),
      .trap      (trap),
      .taken_cnt (taken_cnt)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic modelReset();
      m_boot  = 1'b1;
      m_flush = 1'b0;
      m_trap  = 1'b0;
      m_pc    = 32'h0000_0000;
      m_cnt   = 0;
   endtask

   task automatic modelStep(input bit en, input bit res, input logic [31:0] bpc,
                            input logic [31:0] im, input bit st);
      logic [31:0] tgt;
      tgt = bpc + im;
      if (m_trap) begin
         m_trap = 1'b1;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_flush) begin
         m_flush = 1'b0;
      end else if (en && res) begin
         if ((tgt % 4) != 0) begin
            m_trap = 1'b1;
         end else begin
            m_pc    = tgt;
            m_flush = 1'b1;
            m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         end
      end else if (!st) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic applyStimulus(input bit en, input bit res, input logic [31:0] bpc,
                                input logic [31:0] im, input bit st);
      br_en  = en;
      br_res = res;
      br_pc  = bpc;
      imm    = im;
      stall  = st;
      @(posedge clk);
      modelStep(en, res, bpc, im, st);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] e_pc, input bit e_valid,
                              input bit e_flush, input bit e_trap, input int e_cnt);
      checks += 5;
      if (pc !== e_pc) begin
         errors++;
         $display("[TB] FAIL %s pc got %h want %h", name, pc, e_pc);
      end
      if (pc_valid !== e_valid) begin
         errors++;
         $display("[TB] FAIL %s pc_valid got %b want %b", name, pc_valid, e_valid);
      end
      if (flush !== e_flush) begin
         errors++;
         $display("[TB] FAIL %s flush got %b want %b", name, flush, e_flush);
      end
      if (trap !== e_trap) begin
         errors++;
         $display("[TB] FAIL %s trap got %b want %b", name, trap, e_trap);
      end
      if (int'(taken_cnt) != e_cnt) begin
         errors++;
         $display("[TB] FAIL %s taken_cnt got %0d want %0d", name, taken_cnt, e_cnt);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, m_pc, !(m_boot || m_flush || m_trap), m_flush, m_trap, m_cnt);
   endtask

   // Asynchronous reset pulse away from the edge; outputs must clear at once
   task automatic resetPulse(input string name);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput(name, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Main sequence
   initial begin
      vecs[0]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0000_0000, 1, 0, 0, 0};
      vecs[1]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0000_0004, 1, 0, 0, 0};
      vecs[2]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0000_0008, 1, 0, 0, 0};
      vecs[3]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0000_000C, 1, 0, 0, 0};
      vecs[4]  = '{1, 1, 32'h100,       32'hFFFF_FFF0, 0, 32'h0000_00F0, 0, 1, 0, 1};
      vecs[5]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0000_00F0, 1, 0, 0, 1};
      vecs[6]  = '{1, 0, 32'h123,       32'h7,         1, 32'h0000_00F0, 1, 0, 0, 1};
      vecs[7]  = '{1, 1, 32'h40,        32'h10,        1, 32'h0000_0050, 0, 1, 0, 2};
      vecs[8]  = '{1, 1, 32'h200,       32'h6,         0, 32'h0000_0050, 1, 0, 0, 2};
      vecs[9]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0000_0054, 1, 0, 0, 2};
      vecs[10] = '{1, 1, 32'h200,       32'h6,         0, 32'h0000_0054, 0, 0, 1, 2};
      vecs[11] = '{1, 1, 32'h100,       32'h0,         0, 32'h0000_0054, 0, 0, 1, 2};
      vecs[12] = '{0, 0, 32'h0,         32'h0,         1, 32'h0000_0054, 0, 0, 1, 2};

      rst_n  = 1'b0;
      br_en  = 1'b0;
      br_res = 1'b0;
      br_pc  = '0;
      imm    = '0;
      stall  = 1'b0;
      modelReset();
      #3;
      checkOutput("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].en, vecs[i].res, vecs[i].bpc, vecs[i].im, vecs[i].st);
         checkOutput($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                     vecs[i].e_flush, vecs[i].e_trap, vecs[i].e_cnt);
      end

      resetPulse("reset_in_trap");

      applyStimulus(0, 0, 32'h0, 32'h0, 0);
      checkOutput("boot_after_trap", 32'h0, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1, 1, 32'h300, 32'h20, 0);
      checkOutput("pre_flush_reset", 32'h320, 1'b0, 1'b1, 1'b0, 1);
      resetPulse("reset_in_flush");

      // Saturation of the taken counter
      applyStimulus(0, 0, 32'h0, 32'h0, 0);
      checkModel("sat_boot");
      for (int k = 0; k < 18; k++) begin
         applyStimulus(1, 1, 32'h1000 + 32'(k * 16), 32'h20, k[0]);
         checkModel($sformatf("sat_taken%0d", k));
         applyStimulus(0, 0, 32'h0, 32'h0, 0);
         checkModel($sformatf("sat_flush%0d", k));
      end
      checks++;
      if (taken_cnt !== 4'hF) begin
         errors++;
         $display("[TB] FAIL sat_final taken_cnt got %h want %h", taken_cnt, 4'hF);
      end

      // PC wrap-around at the top of the address space
      applyStimulus(1, 1, 32'hFFFF_FFF0, 32'h8, 0);
      checkOutput("wrap_branch", 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 15);
      applyStimulus(0, 0, 32'h0, 32'h0, 0);
      checkOutput("wrap_flush_done", 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 15);
      applyStimulus(0, 0, 32'h0, 32'h0, 0);
      checkOutput("wrap_fffc", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 15);
      applyStimulus(0, 0, 32'h0, 32'h0, 0);
      checkOutput("wrap_zero", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 15);

      // Random stimulus against the model
      resetPulse("rand_reset");
      for (int n = 0; n < 600; n++) begin
         logic [31:0] rbpc;
         logic [31:0] rim;
         rbpc = $urandom & 32'hFFFF_FFFC;
         rim  = ($urandom_range(0, 19) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rbpc, rim,
                       ($urandom_range(0, 2) == 0));
         checkModel($sformatf("rand%0d", n));
         if ((m_trap && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
            resetPulse($sformatf("rand_reset%0d", n));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
